// File: rtl/ddr_rd_pixel_unpacker.sv
// DDR read pixel unpacker.
// Pops wide words from the prefetch FIFO and emits them as a pixel stream,
// least-significant slice first. Start/end-of-line and start/end-of-frame
// markers are generated from h/v counters that track a fixed active resolution.
module ddr_rd_pixel_unpacker #(
   parameter int unsigned c_IN_WIDTH  = 32,
   parameter int unsigned c_PIX_WIDTH = 16,
   parameter int unsigned c_H_PIX     = 1280,
   parameter int unsigned c_V_LINES   = 720,
   parameter int unsigned c_CNT_WIDTH = 12
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic                   frame_start,
   input  logic [c_IN_WIDTH-1:0]  fifo_data,
   input  logic                   fifo_vld,
   output logic                   fifo_rd_en,
   output logic [c_PIX_WIDTH-1:0] pix_data,
   output logic                   pix_vld,
   input  logic                   pix_rdy,
   output logic                   pix_sof,
   output logic                   pix_eof,
   output logic                   pix_sol,
   output logic                   pix_eol,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   frame_restart
);

   // Pixels per FIFO word and width of the slice index (kept at 1 bit when
   // there is only one slice; it then never leaves 0).
   localparam int unsigned c_RATIO     = c_IN_WIDTH / c_PIX_WIDTH;
   localparam int unsigned c_SEL_WIDTH = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;

   localparam logic [c_SEL_WIDTH-1:0] c_SEL_LAST = c_SEL_WIDTH'(c_RATIO - 1);
   localparam logic [c_CNT_WIDTH-1:0] c_H_LAST   = c_CNT_WIDTH'(c_H_PIX - 1);
   localparam logic [c_CNT_WIDTH-1:0] c_V_LAST   = c_CNT_WIDTH'(c_V_LINES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [c_IN_WIDTH-1:0]  word_reg, word_reg_d;
   logic                   word_vld, word_vld_d;
   logic [c_SEL_WIDTH-1:0] sel, sel_d;
   logic [c_CNT_WIDTH-1:0] h_cnt, h_cnt_d;
   logic [c_CNT_WIDTH-1:0] v_cnt, v_cnt_d;

   logic run;
   logic accept;
   logic sel_last;
   logic h_last;
   logic last_pix;
   logic pop;
   logic restart;
   logic start_new;

   // Handshake and decode terms shared by the FSM and the datapath.
   always_comb begin
      run       = (state_q == StRun);
      pix_vld   = word_vld & run;
      accept    = pix_vld & pix_rdy;
      sel_last  = (sel == c_SEL_LAST);
      h_last    = (h_cnt == c_H_LAST);
      last_pix  = h_last & (v_cnt == c_V_LAST);
      // Pop into an empty holder, or overlap the pop with the accept of the
      // final slice so a steady stream runs at one pixel per clock. The last
      // pixel of a frame never pops: the next word belongs to the next frame.
      pop       = run & fifo_vld &
                  (~word_vld | (accept & sel_last & ~last_pix));
      restart   = run & frame_start;
      start_new = (state_q != StRun) & frame_start;
   end

   // Frame sequencing: IDLE -> RUN -> DONE -> IDLE, restart stays in RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!frame_start && accept && last_pix) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = frame_start ? StRun : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Holding register, slice index and raster counters next-state.
   always_comb begin
      word_reg_d = word_reg;
      word_vld_d = word_vld;
      sel_d      = sel;
      h_cnt_d    = h_cnt;
      v_cnt_d    = v_cnt;

      if (start_new) begin
         // Arming from IDLE/DONE starts from a clean raster position.
         word_vld_d = 1'b0;
         sel_d      = '0;
         h_cnt_d    = '0;
         v_cnt_d    = '0;
      end else if (restart) begin
         // Drop the partially consumed word; a word popped this cycle is
         // already the first word of the new frame.
         word_vld_d = pop;
         sel_d      = '0;
         h_cnt_d    = '0;
         v_cnt_d    = '0;
         if (pop) begin
            word_reg_d = fifo_data;
         end
      end else begin
         if (accept) begin
            if (sel_last) begin
               word_vld_d = 1'b0;
            end else begin
               sel_d = sel + c_SEL_WIDTH'(1);
            end

            if (last_pix) begin
               h_cnt_d    = '0;
               v_cnt_d    = '0;
               sel_d      = '0;
               word_vld_d = 1'b0;
            end else if (h_last) begin
               h_cnt_d = '0;
               v_cnt_d = v_cnt + c_CNT_WIDTH'(1);
            end else begin
               h_cnt_d = h_cnt + c_CNT_WIDTH'(1);
            end
         end

         // A pop only coincides with an accept of the last slice, so it
         // simply overrides the drain above.
         if (pop) begin
            word_reg_d = fifo_data;
            word_vld_d = 1'b1;
            sel_d      = '0;
         end
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q  <= StIdle;
         word_reg <= '0;
         word_vld <= 1'b0;
         sel      <= '0;
         h_cnt    <= '0;
         v_cnt    <= '0;
      end else begin
         state_q  <= state_d;
         word_reg <= word_reg_d;
         word_vld <= word_vld_d;
         sel      <= sel_d;
         h_cnt    <= h_cnt_d;
         v_cnt    <= v_cnt_d;
      end
   end

   // Slice mux and stream-side outputs.
   always_comb begin
      pix_data = '0;
      for (int unsigned i = 0; i < c_RATIO; i++) begin
         if (sel == c_SEL_WIDTH'(i)) begin
            pix_data = word_reg[i*c_PIX_WIDTH +: c_PIX_WIDTH];
         end
      end

      // Markers are qualified so they read 0 whenever no pixel is offered.
      pix_sol       = pix_vld & (h_cnt == '0);
      pix_eol       = pix_vld & h_last;
      pix_sof       = pix_vld & (h_cnt == '0) & (v_cnt == '0);
      pix_eof       = pix_vld & last_pix;

      fifo_rd_en    = pop;
      busy          = (state_q != StIdle);
      frame_done    = (state_q == StDone);
      frame_restart = restart;
   end

endmodule

// File: tb/tb_ddr_rd_pixel_unpacker.sv
// Directed bench for ddr_rd_pixel_unpacker with a 4x2 frame of 16-bit pixels
// packed two per 32-bit FIFO word.
module tb_ddr_rd_pixel_unpacker;

   logic        rd_clk;
   logic        rd_rst;
   logic        frame_start;
   logic [31:0] fifo_data;
   logic        fifo_vld;
   logic        fifo_rd_en;
   logic [15:0] pix_data;
   logic        pix_vld;
   logic        pix_rdy;
   logic        pix_sof, pix_eof, pix_sol, pix_eol;
   logic        busy;
   logic        frame_done;
   logic        frame_restart;

   ddr_rd_pixel_unpacker #(
      .c_IN_WIDTH (32),
      .c_PIX_WIDTH(16),
      .c_H_PIX    (4),
      .c_V_LINES  (2),
      .c_CNT_WIDTH(12)
   ) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .frame_start  (frame_start),
      .fifo_data    (fifo_data),
      .fifo_vld     (fifo_vld),
      .fifo_rd_en   (fifo_rd_en),
      .pix_data     (pix_data),
      .pix_vld      (pix_vld),
      .pix_rdy      (pix_rdy),
      .pix_sof      (pix_sof),
      .pix_eof      (pix_eof),
      .pix_sol      (pix_sol),
      .pix_eol      (pix_eol),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_restart(frame_restart)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   int checks = 0;
   int errors = 0;

   // FIFO model and stimulus controls
   logic [31:0] fifo_q[$];
   bit          fifo_en;
   bit          pop_pend;
   bit          fs_req;
   int          rdy_mode;
   int          phase;
   int          cyc = 0;
   int          restart_at;
   bit          restart_hit;
   int          b2b_at;
   bit          b2b_hit;
   int          starve_after;
   int          starve_left;
   int          fs_cyc;

   // Observations
   logic [15:0] cap_data[$];
   logic [3:0]  cap_mk[$];
   int          cap_cyc[$];
   int          done_cyc[$];
   int          restart_cyc[$];
   int          pops, hold_cnt, stab_viol, undrained_pop, idle_pop, busy_cnt;
   bit          hold_prev;
   logic [19:0] hold_val;

   // Expected markers {sof, eof, sol, eol} for pixels 0..7 of a 4x2 frame
   logic [3:0]  frame_mk[8] = '{4'b1010, 4'b0000, 4'b0000, 4'b0001,
                                4'b0010, 4'b0000, 4'b0000, 4'b0101};
   logic [31:0] frame_words[4] = '{32'h0001_0000, 32'h0003_0002,
                                   32'h0005_0004, 32'h0007_0006};
   logic [31:0] alt_words[4]   = '{32'h0011_0010, 32'h0013_0012,
                                   32'h0015_0014, 32'h0017_0016};

   logic [15:0] ed[$];
   logic [3:0]  em[$];

   task automatic clear_test();
      cap_data.delete(); cap_mk.delete(); cap_cyc.delete();
      done_cyc.delete(); restart_cyc.delete(); ed.delete(); em.delete();
      pops = 0; hold_cnt = 0; stab_viol = 0; undrained_pop = 0; idle_pop = 0;
      busy_cnt = 0; hold_prev = 0; rdy_mode = 0; phase = 0;
      restart_at = -1; restart_hit = 0; b2b_at = -1; b2b_hit = 0;
      starve_after = -1; starve_left = 0; fs_req = 0; fs_cyc = -1;
   endtask

   task automatic push_frame(input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         ed.push_back(base + 16'(i));
         em.push_back(frame_mk[i]);
      end
   endtask

   // One clock: drive after the rising edge, observe on the falling edge.
   task automatic step();
      logic [3:0] mk;
      @(posedge rd_clk);
      #1;
      if (pop_pend) begin
         void'(fifo_q.pop_front());
         pop_pend = 0;
      end
      pix_rdy = (rdy_mode == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
      phase++;
      frame_start = 1'b0;
      if (fs_req) begin
         frame_start = 1'b1;
         fs_req = 0;
      end
      if (restart_at >= 0 && !restart_hit && cap_data.size() == restart_at) begin
         frame_start = 1'b1;
         pix_rdy = 1'b0;
         restart_hit = 1;
      end
      if (b2b_at >= 0 && !b2b_hit && cap_data.size() == b2b_at) begin
         frame_start = 1'b1;
         b2b_hit = 1;
      end
      if (frame_start) fs_cyc = cyc;
      fifo_vld = fifo_en && (fifo_q.size() > 0);
      if (starve_after >= 0 && pops >= starve_after && starve_left > 0) begin
         fifo_vld = 1'b0;
         starve_left--;
      end
      fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
      @(negedge rd_clk);
      mk = {pix_sof, pix_eof, pix_sol, pix_eol};
      if (fifo_rd_en && fifo_vld) begin
         pops++;
         pop_pend = 1;
      end
      if (fifo_rd_en && !busy) idle_pop++;
      if (fifo_rd_en && pix_vld && !pix_rdy) undrained_pop++;
      if (hold_prev && (!pix_vld || {pix_data, mk} !== hold_val)) stab_viol++;
      hold_prev = pix_vld && !pix_rdy && !frame_start;
      if (hold_prev) hold_cnt++;
      hold_val = {pix_data, mk};
      if (pix_vld && pix_rdy) begin
         cap_data.push_back(pix_data);
         cap_mk.push_back(mk);
         cap_cyc.push_back(cyc);
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (frame_restart) restart_cyc.push_back(cyc);
      if (busy) busy_cnt++;
      cyc++;
   endtask

   task automatic run_until_done(input int target, input int budget);
      for (int n = 0; n < budget && done_cyc.size() < target; n++) step();
      for (int n = 0; n < 3; n++) step();
   endtask

   task automatic test_reset();
      rd_rst = 1'b1; frame_start = 1'b1; fifo_vld = 1'b1;
      fifo_data = 32'h1234_5678; pix_rdy = 1'b1; fifo_en = 0; pop_pend = 0;
      repeat (3) @(posedge rd_clk);
      @(negedge rd_clk);
      checks++; if (fifo_rd_en !== 1'b0) begin errors++;
         $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      checks++; if (pix_vld !== 1'b0) begin errors++;
         $display("FAIL reset_pix_vld: got %b want 0", pix_vld); end
      checks++; if (pix_data !== 16'h0) begin errors++;
         $display("FAIL reset_pix_data: got %h want 0000", pix_data); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({frame_done, frame_restart} !== 2'b00) begin errors++;
         $display("FAIL reset_pulses: got %b want 00", {frame_done, frame_restart}); end
      checks++; if ({pix_sof, pix_eof, pix_sol, pix_eol} !== 4'b0) begin errors++;
         $display("FAIL reset_markers: got %b want 0000",
                  {pix_sof, pix_eof, pix_sol, pix_eol}); end
      rd_rst = 1'b0; frame_start = 1'b0; fifo_vld = 1'b0;
   endtask

   task automatic test_basic();
      clear_test();
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      fifo_en = 1; fs_req = 1;
      push_frame(16'h0000);
      run_until_done(1, 40);
      checks++; if (cap_data.size() !== 8) begin errors++;
         $display("FAIL basic_count: got %0d pixels want 8", cap_data.size()); end
      for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
         checks++;
         if (cap_data[i] !== ed[i] || cap_mk[i] !== em[i]) begin errors++;
            $display("FAIL basic_pix%0d: got %h/%b want %h/%b", i, cap_data[i], cap_mk[i],
                     ed[i], em[i]); end
      end
      checks++; if (cap_cyc.size() == 8 && cap_cyc[0] !== fs_cyc + 2) begin errors++;
         $display("FAIL basic_latency: first pixel cycle %0d want %0d", cap_cyc[0], fs_cyc + 2); end
      checks++; if (cap_cyc.size() == 8 && cap_cyc[7] - cap_cyc[0] !== 7) begin errors++;
         $display("FAIL basic_throughput: span %0d want 7", cap_cyc[7] - cap_cyc[0]); end
      checks++;
      if (done_cyc.size() !== 1 || cap_cyc.size() != 8 || done_cyc[0] !== cap_cyc[7] + 1) begin
         errors++;
         $display("FAIL basic_done: %0d pulses want 1 at last-pixel+1", done_cyc.size()); end
      checks++; if (pops !== 4) begin errors++;
         $display("FAIL basic_pops: got %0d want 4", pops); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL basic_idle_after: busy %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      clear_test();
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      fifo_en = 1; fs_req = 1; rdy_mode = 1;
      push_frame(16'h0000);
      run_until_done(1, 60);
      checks++; if (cap_data.size() !== 8) begin errors++;
         $display("FAIL bp_count: got %0d pixels want 8", cap_data.size()); end
      for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
         checks++;
         if (cap_data[i] !== ed[i] || cap_mk[i] !== em[i]) begin errors++;
            $display("FAIL bp_pix%0d: got %h/%b want %h/%b", i, cap_data[i], cap_mk[i],
                     ed[i], em[i]); end
      end
      checks++; if (hold_cnt == 0 || stab_viol !== 0) begin errors++;
         $display("FAIL bp_stable: %0d unstable of %0d held cycles want 0", stab_viol, hold_cnt); end
      checks++; if (undrained_pop !== 0) begin errors++;
         $display("FAIL bp_undrained_pop: got %0d want 0", undrained_pop); end
      checks++; if (pops !== 4 || done_cyc.size() !== 1) begin errors++;
         $display("FAIL bp_pops_done: pops %0d done %0d want 4 1", pops, done_cyc.size()); end
   endtask

   task automatic test_starvation();
      clear_test();
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      fifo_en = 1; fs_req = 1; starve_after = 2; starve_left = 5;
      push_frame(16'h0000);
      run_until_done(1, 50);
      checks++; if (cap_data.size() !== 8) begin errors++;
         $display("FAIL starve_count: got %0d pixels want 8", cap_data.size()); end
      for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
         checks++;
         if (cap_data[i] !== ed[i] || cap_mk[i] !== em[i]) begin errors++;
            $display("FAIL starve_pix%0d: got %h/%b want %h/%b", i, cap_data[i], cap_mk[i],
                     ed[i], em[i]); end
      end
      checks++; if (cap_cyc.size() == 8 && cap_cyc[4] - cap_cyc[3] !== 5) begin errors++;
         $display("FAIL starve_gap: got %0d cycles want 5", cap_cyc[4] - cap_cyc[3]); end
      checks++; if (pops !== 4 || done_cyc.size() !== 1) begin errors++;
         $display("FAIL starve_pops_done: pops %0d done %0d want 4 1", pops, done_cyc.size()); end
   endtask

   task automatic test_restart();
      clear_test();
      fifo_q.push_back(frame_words[0]);
      fifo_q.push_back(frame_words[1]);
      foreach (alt_words[i]) fifo_q.push_back(alt_words[i]);
      fifo_en = 1; fs_req = 1; restart_at = 3;
      for (int i = 0; i < 3; i++) begin
         ed.push_back(16'(i));
         em.push_back(frame_mk[i]);
      end
      push_frame(16'h0010);
      run_until_done(1, 50);
      checks++; if (cap_data.size() !== 11) begin errors++;
         $display("FAIL restart_count: got %0d pixels want 11", cap_data.size()); end
      for (int i = 0; i < 11 && i < cap_data.size(); i++) begin
         checks++;
         if (cap_data[i] !== ed[i] || cap_mk[i] !== em[i]) begin errors++;
            $display("FAIL restart_pix%0d: got %h/%b want %h/%b", i, cap_data[i], cap_mk[i],
                     ed[i], em[i]); end
      end
      checks++;
      if (restart_cyc.size() !== 1 || restart_cyc[0] !== fs_cyc) begin errors++;
         $display("FAIL restart_pulse: %0d pulses want 1 in the frame_start cycle",
                  restart_cyc.size()); end
      checks++; if (pops !== 6 || done_cyc.size() !== 1) begin errors++;
         $display("FAIL restart_pops_done: pops %0d done %0d want 6 1", pops, done_cyc.size()); end
   endtask

   task automatic test_idle_b2b();
      clear_test();
      for (int f = 0; f < 2; f++) foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      fifo_en = 1;
      for (int n = 0; n < 10; n++) step();
      checks++; if (pops !== 0 || idle_pop !== 0 || fifo_q.size() !== 8) begin errors++;
         $display("FAIL idle_holdoff: pops %0d words left %0d want 0 8", pops, fifo_q.size()); end
      fs_req = 1; b2b_at = 8;
      push_frame(16'h0000);
      push_frame(16'h0000);
      run_until_done(2, 60);
      checks++; if (cap_data.size() !== 16) begin errors++;
         $display("FAIL b2b_count: got %0d pixels want 16", cap_data.size()); end
      for (int i = 0; i < 16 && i < cap_data.size(); i++) begin
         checks++;
         if (cap_data[i] !== ed[i] || cap_mk[i] !== em[i]) begin errors++;
            $display("FAIL b2b_pix%0d: got %h/%b want %h/%b", i, cap_data[i], cap_mk[i],
                     ed[i], em[i]); end
      end
      checks++; if (cap_cyc.size() == 16 && cap_cyc[8] !== cap_cyc[7] + 3) begin errors++;
         $display("FAIL b2b_gap: second frame at %0d want %0d", cap_cyc[8], cap_cyc[7] + 3); end
      checks++; if (done_cyc.size() !== 2 || idle_pop !== 0) begin errors++;
         $display("FAIL b2b_done: %0d done pulses %0d idle pops want 2 0",
                  done_cyc.size(), idle_pop); end
   endtask

   task automatic test_reset_mid();
      clear_test();
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      fifo_en = 1; fs_req = 1;
      for (int n = 0; n < 30 && cap_data.size() < 6; n++) step();
      checks++; if (cap_data.size() !== 6) begin errors++;
         $display("FAIL rstmid_reach: got %0d pixels want 6", cap_data.size()); end
      #2;
      rd_rst = 1'b1;
      #1;
      checks++;
      if ({fifo_rd_en, pix_vld, busy, frame_done, frame_restart} !== 5'b0 ||
          pix_data !== 16'h0 || {pix_sof, pix_eof, pix_sol, pix_eol} !== 4'b0) begin errors++;
         $display("FAIL rstmid_async: rd_en %b vld %b busy %b done %b rst %b data %h mk %b want 0",
                  fifo_rd_en, pix_vld, busy, frame_done, frame_restart, pix_data,
                  {pix_sof, pix_eof, pix_sol, pix_eol}); end
      repeat (2) @(posedge rd_clk);
      @(negedge rd_clk);
      rd_rst = 1'b0;
      clear_test();
      pop_pend = 0;
      fifo_q.delete();
      foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
      for (int n = 0; n < 5; n++) step();
      checks++; if (busy_cnt !== 0 || pops !== 0) begin errors++;
         $display("FAIL rstmid_idle: busy cycles %0d pops %0d want 0 0", busy_cnt, pops); end
      fs_req = 1;
      push_frame(16'h0000);
      run_until_done(1, 40);
      checks++; if (cap_data.size() !== 8) begin errors++;
         $display("FAIL rstmid_recover: got %0d pixels want 8", cap_data.size()); end
      for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
         checks++;
         if (cap_data[i] !== ed[i] || cap_mk[i] !== em[i]) begin errors++;
            $display("FAIL rstmid_pix%0d: got %h/%b want %h/%b", i, cap_data[i], cap_mk[i],
                     ed[i], em[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_starvation();
      test_restart();
      test_idle_b2b();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
